// File: rtl/led_fade_pwm_pkg.sv
// Shared constants, brightness type and decay helper for the LED fade display stage.
package led_fade_pkg;

    localparam int unsigned PWM_BITS           = 8;
    localparam int unsigned MAX_BRIGHT         = 255;
    localparam int unsigned PWM_LAST           = 254;
    localparam int unsigned DEFAULT_W          = 8;
    localparam int unsigned DEFAULT_DECAY_STEP = 16;

    typedef logic [PWM_BITS-1:0] brightness_t;

    // Saturating subtract: a fading LED bottoms out at 0 instead of wrapping to full.
    function automatic brightness_t decay(input brightness_t b, input brightness_t step);
        return (b > step) ? brightness_t'(b - step) : '0;
    endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern/tick inputs and LED/wrap outputs of the fade stage, bundled as one port.
interface led_fade_pwm_if import led_fade_pkg::*; #(
    parameter int unsigned W = DEFAULT_W
);

    logic         tick;
    logic [W-1:0] pattern;
    logic [W-1:0] led;
    logic         pwm_wrap;

    modport master (
        output tick,
        output pattern,
        input  led,
        input  pwm_wrap
    );

    modport slave (
        input  tick,
        input  pattern,
        output led,
        output pwm_wrap
    );

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness register with set/decay priority and the PWM compare flop.
module led_fade_channel import led_fade_pkg::*; #(
    parameter int unsigned DECAY_STEP = DEFAULT_DECAY_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pat_s,
    input  logic        decay_stb,
    input  brightness_t pc,
    output logic        led
);

    localparam brightness_t Step = brightness_t'(DECAY_STEP);
    localparam brightness_t Full = brightness_t'(MAX_BRIGHT);

    brightness_t b_q, b_d;
    logic        led_q;

    // Next brightness: a lit bit wins over a same-cycle decay strobe.
    always_comb begin
        b_d = b_q;
        if (pat_s) begin
            b_d = Full;
        end else if (decay_stb) begin
            b_d = decay(b_q, Step);
        end
    end

    // Brightness state and registered PWM compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= '0;
            led_q <= 1'b0;
        end else begin
            b_q   <= b_d;
            led_q <= (pc < b_q);
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// Comet-tail LED driver: syncs pattern/tick, runs the shared PWM counter, fans out channels.
module led_fade_pwm import led_fade_pkg::*; #(
    parameter int unsigned W          = DEFAULT_W,
    parameter int unsigned DECAY_STEP = DEFAULT_DECAY_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    led_fade_pwm_if.slave      bus
);

    localparam brightness_t PcLast = brightness_t'(PWM_LAST);

    logic [W-1:0] pat_m, pat_s;
    logic         tick_m, tick_s, tick_d;
    logic         decay_stb;
    brightness_t  pc_q, pc_d;
    logic         pwm_wrap_q;
    logic [W-1:0] led_vec;

    // Two-flop synchronisers for pattern bits and tick, plus the tick edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_m  <= '0;
            pat_s  <= '0;
            tick_m <= 1'b0;
            tick_s <= 1'b0;
            tick_d <= 1'b0;
        end else begin
            pat_m  <= bus.pattern;
            pat_s  <= pat_m;
            tick_m <= bus.tick;
            tick_s <= tick_m;
            tick_d <= tick_s;
        end
    end

    assign decay_stb = tick_s & ~tick_d;

    // PWM counter runs 0..254 so that b=255 is on in every cycle of the period.
    always_comb begin
        pc_d = pc_q + brightness_t'(1);
        if (pc_q == PcLast) begin
            pc_d = '0;
        end
    end

    // PWM counter and wrap pulse; the wrap flag is high while pc reads 0 after a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            pwm_wrap_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pwm_wrap_q <= (pc_q == PcLast);
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_chan
        led_fade_channel #(
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .pat_s     (pat_s[i]),
            .decay_stb (decay_stb),
            .pc        (pc_q),
            .led       (led_vec[i])
        );
    end

    assign bus.led      = led_vec;
    assign bus.pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: expectations queued at stimulus, popped at measurement.
module tb_led_fade_pwm;
    import led_fade_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned STEP = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_fade_pwm_if #(.W(W)) bus ();

    led_fade_pwm #(
        .W          (W),
        .DECAY_STEP (STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High-count of one LED over one full PWM period, sampled on falling edges.
    task automatic count_high(input int ch, output logic [31:0] cnt);
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (bus.led[ch] === 1'b1) cnt++;
        end
    endtask

    task automatic strobe(input int hi, input int lo);
        bus.tick = 1'b1;
        wait_clks(hi);
        bus.tick = 1'b0;
        wait_clks(lo);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        int          led_bad;
        int          first_wrap;
        int          guard;
        bus.pattern = '0;
        bus.tick    = 1'b0;
        rst_n       = 1'b0;
        wait_clks(3);
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (bus.led !== e[W-1:0]) begin
            errors++; $display("FAIL reset_led_init: got %h expected %h", bus.led, e[W-1:0]);
        end
        e = exp_q.pop_front(); checks++;
        if (bus.pwm_wrap !== e[0]) begin
            errors++; $display("FAIL reset_wrap_init: got %b expected %b", bus.pwm_wrap, e[0]);
        end

        rst_n       = 1'b1;
        bus.pattern = 8'hFF;
        wait_clks(1000);
        exp_q.push_back(32'hFF);
        e = exp_q.pop_front(); checks++;
        if (bus.led !== e[W-1:0]) begin
            errors++; $display("FAIL all_on: got %h expected %h", bus.led, e[W-1:0]);
        end

        // Assert reset between edges while a wrap pulse is visible.
        guard = 0;
        while (bus.pwm_wrap !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h0);
        rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.led !== e[W-1:0]) begin
            errors++; $display("FAIL async_reset_led: got %h expected %h", bus.led, e[W-1:0]);
        end
        e = exp_q.pop_front(); checks++;
        if (bus.pwm_wrap !== e[0] || guard >= 300) begin
            errors++;
            $display("FAIL async_reset_wrap: got %b expected %b (wait %0d)", bus.pwm_wrap, e[0],
                     guard);
        end

        bus.pattern = '0;
        wait_clks(3);
        rst_n = 1'b1;
        led_bad    = 0;
        first_wrap = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.led !== 8'h00) led_bad++;
            if (bus.pwm_wrap === 1'b1 && first_wrap == 0) first_wrap = k;
        end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd255);
        e = exp_q.pop_front(); checks++;
        if (led_bad !== int'(e)) begin
            errors++; $display("FAIL reset_no_tail: got %0d lit cycles expected %0d", led_bad, e);
        end
        e = exp_q.pop_front(); checks++;
        if (first_wrap !== int'(e)) begin
            errors++; $display("FAIL first_wrap: got cycle %0d expected %0d", first_wrap, e);
        end
    endtask

    task automatic test_steady_on();
        logic [31:0] e;
        int          led_bad;
        int          nwrap;
        int          wraps[4];
        bus.pattern = 8'h01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); checks++;
        if (bus.led[0] !== e[0]) begin
            errors++; $display("FAIL on_latency: got %b expected %b", bus.led[0], e[0]);
        end

        led_bad = 0;
        nwrap   = 0;
        for (int k = 0; k < 1100 && nwrap < 4; k++) begin
            @(negedge clk);
            if (bus.led !== 8'h01) led_bad++;
            if (bus.pwm_wrap === 1'b1) begin
                wraps[nwrap] = k;
                nwrap++;
            end
        end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        e = exp_q.pop_front(); checks++;
        if (led_bad !== int'(e)) begin
            errors++; $display("FAIL steady_on: got %0d bad cycles expected %0d", led_bad, e);
        end
        e = exp_q.pop_front(); checks++;
        if (nwrap !== int'(e)) begin
            errors++; $display("FAIL wrap_count: got %0d expected %0d", nwrap, e);
        end else begin
            for (int i = 1; i < 4; i++) begin
                exp_q.push_back(32'd255);
                e = exp_q.pop_front(); checks++;
                if (wraps[i] - wraps[i-1] !== int'(e)) begin
                    errors++;
                    $display("FAIL wrap_period: got %0d expected %0d", wraps[i] - wraps[i-1], e);
                end
            end
        end
    endtask

    task automatic test_fade();
        logic [31:0] e;
        logic [31:0] cnt;
        int          model;
        bus.pattern = 8'h00;
        wait_clks(10);
        model = 255;
        for (int k = 1; k <= 18; k++) begin
            model = (model > int'(STEP)) ? model - int'(STEP) : 0;
            exp_q.push_back(32'(model));
            bus.tick = 1'b1;
            wait_clks(10);
            count_high(0, cnt);
            e = exp_q.pop_front(); checks++;
            if (cnt !== e) begin
                errors++; $display("FAIL fade_step%0d: got %0d expected %0d", k, cnt, e);
            end
            bus.tick = 1'b0;
            wait_clks(600 - 265);
        end
    endtask

    task automatic test_tick_held();
        logic [31:0] e;
        logic [31:0] cnt;
        bus.pattern = 8'h01;
        wait_clks(10);
        bus.pattern = 8'h00;
        wait_clks(10);
        exp_q.push_back(32'd239);
        exp_q.push_back(32'd239);
        bus.tick = 1'b1;
        wait_clks(20);
        count_high(0, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL tick_held_early: got %0d expected %0d", cnt, e);
        end
        wait_clks(4700);
        count_high(0, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL tick_held_late: got %0d expected %0d", cnt, e);
        end
        bus.tick = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_simultaneous();
        logic [31:0] e;
        logic [31:0] cnt;
        // Same launch edge for both, so pat_s[3] is high for exactly the strobe cycle.
        bus.pattern = 8'h08;
        bus.tick    = 1'b1;
        wait_clks(1);
        bus.pattern = 8'h00;
        exp_q.push_back(32'd255);
        wait_clks(10);
        count_high(3, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL set_beats_decay: got %0d expected %0d", cnt, e);
        end
        bus.tick = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_retrigger();
        logic [31:0] e;
        logic [31:0] cnt;
        bus.pattern = 8'h04;
        wait_clks(10);
        bus.pattern = 8'h00;
        wait_clks(10);
        for (int k = 0; k < 8; k++) strobe(20, 20);
        exp_q.push_back(32'd127);
        count_high(2, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL mid_fade: got %0d expected %0d", cnt, e);
        end

        bus.pattern = 8'h04;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'd255);
        repeat (4) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.led[2] !== e[0]) begin
            errors++; $display("FAIL retrigger_latency: got %b expected %b", bus.led[2], e[0]);
        end
        count_high(2, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL retrigger_full: got %0d expected %0d", cnt, e);
        end

        bus.pattern = 8'h00;
        wait_clks(10);
        exp_q.push_back(32'd239);
        bus.tick = 1'b1;
        wait_clks(10);
        count_high(2, cnt);
        e = exp_q.pop_front(); checks++;
        if (cnt !== e) begin
            errors++; $display("FAIL retrigger_decay: got %0d expected %0d", cnt, e);
        end
        bus.tick = 1'b0;
        wait_clks(20);
    endtask

    initial begin
        test_reset();
        test_steady_on();
        test_fade();
        test_tick_held();
        test_simultaneous();
        test_retrigger();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
